// File: rtl/la_capture_if.sv
// Bundle between the trigger comparator / control registers and the capture sequencer.
// The master drives the sample stream and control; the slave returns the RAM write port and status.
interface la_capture_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 8
);
  logic              start;
  logic              abort;
  logic              sample_en;
  logic [DATA_W-1:0] din;
  logic              trig_in;
  logic [ADDR_W-1:0] pre_len;
  logic [ADDR_W-1:0] post_len;

  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [ADDR_W-1:0] trig_addr;
  logic [ADDR_W-1:0] start_addr;
  logic              busy;
  logic              triggered;
  logic              done;

  modport master (
    output start, abort, sample_en, din, trig_in, pre_len, post_len,
    input  wr_en, wr_addr, wr_data, trig_addr, start_addr, busy, triggered, done
  );

  modport slave (
    input  start, abort, sample_en, din, trig_in, pre_len, post_len,
    output wr_en, wr_addr, wr_data, trig_addr, start_addr, busy, triggered, done
  );
endinterface

// File: rtl/la_capture.sv
// Capture sequencer: writes the sample stream into a circular RAM, guarantees
// pre_len samples of history before the trigger and post_len samples after it.
module la_capture #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 8
) (
  input  logic        clk,
  input  logic        rst,
  la_capture_if.slave bus
);
  typedef enum logic [2:0] {S_IDLE, S_PRE, S_WAIT, S_POST, S_DONE} state_e;

  state_e            state_q;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [ADDR_W-1:0] pre_len_q, post_len_q;
  logic              wr_en_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [DATA_W-1:0] wr_data_q;
  logic [ADDR_W-1:0] trig_addr_q, start_addr_q;
  logic              busy_q, triggered_q, done_q;
  logic              sample_wr;

  // The pointer wraps 2^ADDR_W-1 -> 0 by plain truncation.
  assign ptr_d     = ptr_q + 1'b1;
  assign cnt_d     = cnt_q + 1'b1;
  assign sample_wr = bus.sample_en &&
                     (state_q == S_PRE || state_q == S_WAIT || state_q == S_POST);

  always_ff @(posedge clk) begin
    // NOTE: synchronous reset - rst is sampled on the clock edge like any other input,
    // and every register here (including the write pointer) is cleared by it.
    if (rst) begin
      state_q      <= S_IDLE;
      ptr_q        <= '0;
      cnt_q        <= '0;
      pre_len_q    <= '0;
      post_len_q   <= '0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      trig_addr_q  <= '0;
      start_addr_q <= '0;
      busy_q       <= 1'b0;
      triggered_q  <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      wr_en_q <= 1'b0;
      if (bus.abort) begin
        state_q <= S_IDLE;
        busy_q  <= 1'b0;
        done_q  <= 1'b0;
      end else begin
        if (sample_wr) begin
          wr_en_q   <= 1'b1;
          wr_addr_q <= ptr_q;
          wr_data_q <= bus.din;
          ptr_q     <= ptr_d;
        end
        case (state_q)
          S_IDLE, S_DONE: begin
            if (bus.start) begin
              pre_len_q   <= bus.pre_len;
              post_len_q  <= bus.post_len;
              ptr_q       <= '0;
              cnt_q       <= '0;
              triggered_q <= 1'b0;
              done_q      <= 1'b0;
              busy_q      <= 1'b1;
              state_q     <= (bus.pre_len == '0) ? S_WAIT : S_PRE;
            end else if (state_q == S_DONE) begin
              // Status lags the state by one cycle so done rises after the last write.
              busy_q <= 1'b0;
              done_q <= 1'b1;
            end
          end
          S_PRE: begin
            if (bus.sample_en) begin
              cnt_q <= cnt_d;
              if (cnt_d == pre_len_q) begin
                cnt_q   <= '0;
                state_q <= S_WAIT;
              end
            end
          end
          S_WAIT: begin
            if (bus.sample_en && bus.trig_in) begin
              trig_addr_q  <= ptr_q;
              start_addr_q <= ptr_q - pre_len_q;
              triggered_q  <= 1'b1;
              cnt_q        <= '0;
              state_q      <= (post_len_q == '0) ? S_DONE : S_POST;
            end
          end
          S_POST: begin
            if (bus.sample_en) begin
              cnt_q <= cnt_d;
              if (cnt_d == post_len_q) state_q <= S_DONE;
            end
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign bus.wr_en      = wr_en_q;
  assign bus.wr_addr    = wr_addr_q;
  assign bus.wr_data    = wr_data_q;
  assign bus.trig_addr  = trig_addr_q;
  assign bus.start_addr = start_addr_q;
  assign bus.busy       = busy_q;
  assign bus.triggered  = triggered_q;
  assign bus.done       = done_q;
endmodule

// File: doc/la_capture.md
Name: la_capture

Overview:
- Capture sequencer for the logic analyser. Sits directly downstream of the trigger comparator.
- Consumes the 8-bit sample stream and the per-sample trigger flag, and writes samples into a circular sample RAM.
- Guarantees a programmable number of pre-trigger samples, then records a programmable number of post-trigger samples.
- Reports the trigger address and the oldest-sample address so the readout logic can unroll the buffer.

Parameters:
- ADDR_W, 10, sample RAM address width; buffer depth = 2^ADDR_W.
- DATA_W, 8, sample width.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- start  in  1  one-cycle pulse; arms a new capture.
- abort  in  1  one-cycle pulse; cancels the capture.
- sample_en  in  1  sample strobe (rate divider); din/trig_in are valid only when high.
- din  in  DATA_W  sample data.
- trig_in  in  1  trigger condition for the current din (1 = hit).
- pre_len  in  ADDR_W  pre-trigger sample count; latched on start.
- post_len  in  ADDR_W  post-trigger sample count, excluding the trigger sample; latched on start.
- wr_en  out  1  RAM write strobe.
- wr_addr  out  ADDR_W  RAM write address.
- wr_data  out  DATA_W  RAM write data.
- trig_addr  out  ADDR_W  address where the trigger sample was written.
- start_addr  out  ADDR_W  address of the oldest valid sample = trig_addr - pre_len mod 2^ADDR_W.
- busy  out  1  capture in progress (PRE, WAIT or POST).
- triggered  out  1  trigger accepted in this capture.
- done  out  1  capture complete.

Behaviour:
- All outputs registered. Reset values: wr_en=0, wr_addr=0, wr_data=0, trig_addr=0, start_addr=0, busy=0, triggered=0, done=0, state=IDLE, counters=0.
- States: IDLE, PRE, WAIT, POST, DONE.
- Write path: in PRE, WAIT or POST, a cycle with sample_en=1 produces, on the next cycle:
  - wr_en=1, wr_data=din, wr_addr=current pointer.
  - Pointer then increments and wraps 2^ADDR_W-1 -> 0.
  - wr_en=0 in every other case; latency exactly 1 clk.
- IDLE/DONE + start:
  - Latch pre_len/post_len; pointer=0; clear triggered and done; busy=1.
  - Go to PRE, or straight to WAIT if pre_len=0.
  - A sample_en in the same cycle as start is not written.
- PRE:
  - Count written samples. trig_in is ignored here, which guarantees pre-trigger history.
  - When the count reaches pre_len (on the sample_en that completes it), go to WAIT next cycle.
- WAIT:
  - Every sample_en writes (circular overwrite allowed).
  - On sample_en with trig_in=1: that sample is written, trig_addr is set to its address, start_addr is updated, triggered=1.
  - Then go to POST, or to DONE if post_len=0.
- POST:
  - Count written samples.
  - When the count reaches post_len, go to DONE: busy=0, done=1 in the cycle after the last wr_en.
- DONE:
  - Hold done=1 and hold trig_addr/start_addr.
  - Ignore sample_en and trig_in.
  - start re-arms.
- abort in any state: next cycle state=IDLE, busy=0, done=0, wr_en=0.
  - triggered/trig_addr/start_addr retain their values.
  - abort wins over a simultaneous start and over a simultaneous trigger.
- start while busy: ignored.
- rst asserted mid-capture: all registers return to reset values on the next edge. No partial write after reset.
- Constraint: pre_len + post_len + 1 <= 2^ADDR_W.
  - If violated, counting still follows the latched values.
  - Oldest samples are overwritten; no error flag.
- Counters are ADDR_W bits and never overflow under the constraint.
- start_addr arithmetic: ADDR_W-bit modular subtraction.

Test Plan:
- rst, then pre_len=4, post_len=3, start, sample_en held high, din=0x00,0x01,..., trig_in=1 at the din=0x06 sample:
  - Writes to addresses 0..9 carry data 0x00..0x09.
  - trig_addr=6, start_addr=2.
  - done=1 one cycle after the wr_en carrying data 0x09.
- trig_in=1 during the PRE samples (pre_len=4, trigger on the 2nd sample):
  - Trigger ignored; state stays in PRE, then WAIT; triggered=0 until a later trig_in=1 in WAIT.
- ADDR_W=4, pre_len=2, post_len=2, trigger after 20 samples in WAIT:
  - wr_addr wraps 15 -> 0.
  - trig_addr=(pre samples + WAIT samples - 1) mod 16.
  - start_addr=trig_addr-2 mod 16 (e.g. trig_addr=1 -> start_addr=15).
- pre_len=0, post_len=0, trig_in=1 on the first sample_en after start:
  - Exactly one write at address 0; trig_addr=0, start_addr=0; done=1 next cycle.
- Sparse sample_en (1 in 4 cycles):
  - wr_en pulses exactly once per strobe, 1 clk later.
  - No writes in cycles without a strobe.
  - done asserts only after post_len post-trigger strobes.
- abort in POST, then start and abort in the same cycle, then rst mid-WAIT:
  - Each returns to IDLE with busy=0, done=0, wr_en=0 next cycle.
  - After rst, all outputs are 0.
